// File: rtl/fetch_unit_if.sv
// Instruction-memory channel between the fetch stage and imem:
// valid/ready request, valid-only in-order response.
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// IF stage: owns PCF and the IF/ID register, fetches from a variable-latency imem
// with at most one request outstanding and a one-entry skid buffer.
//   state  | meaning
//   S_REQ  | request pending at PCF
//   S_WAIT | one request outstanding at PCF
//   S_HOLD | response parked in skid buffer
//   S_DROP | stale request outstanding, its response will be discarded
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = 'h13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF_i,
    input  logic              StallD_i,
    input  logic              FlushD_i,
    input  logic              PCSrcE_i,
    input  logic [XLEN-1:0]   PCTargetE_i,
    fetch_unit_if.master      imem,
    output logic [XLEN-1:0]   InstrD_o,
    output logic [XLEN-1:0]   PCD_o,
    output logic [XLEN-1:0]   PCPlus4D_o,
    output logic              ValidD_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcd_q, pcd_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            validd_q, validd_d;

    logic [XLEN-1:0] pc_plus4;
    logic            consume;
    logic            req_fire;
    logic            load;
    logic [XLEN-1:0] load_instr;

    assign pc_plus4 = pcf_q + XLEN'(4);
    assign consume  = !StallD_i && !FlushD_i && !PCSrcE_i;

    assign imem.req_valid = !PCSrcE_i && !StallF_i &&
                            ((state_q == S_REQ) ||
                             (state_q == S_WAIT && imem.rsp_valid && consume));
    assign imem.req_addr  = (state_q == S_WAIT) ? pc_plus4 : pcf_q;
    assign req_fire       = imem.req_valid && imem.req_ready;

    always_comb begin
        state_d    = state_q;
        pcf_d      = pcf_q;
        buf_d      = buf_q;
        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pcp4_d     = pcp4_q;
        validd_d   = validd_q;
        load       = 1'b0;
        load_instr = buf_q;

        if (PCSrcE_i) begin
            pcf_d = PCTargetE_i;
            // A response arriving alongside the redirect retires the stale request,
            // so only a still-unanswered request needs the DROP state.
            if ((state_q == S_WAIT || state_q == S_DROP) && !imem.rsp_valid)
                state_d = S_DROP;
            else
                state_d = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem.rsp_valid) begin
                        if (consume) begin
                            load       = 1'b1;
                            load_instr = imem.rsp_data;
                            pcf_d      = pc_plus4;
                            state_d    = req_fire ? S_WAIT : S_REQ;
                        end else begin
                            buf_d   = imem.rsp_data;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        load       = 1'b1;
                        load_instr = buf_q;
                        pcf_d      = pc_plus4;
                        state_d    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem.rsp_valid) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end

        if (FlushD_i) begin
            instr_d  = NOP;
            validd_d = 1'b0;
        end else if (!StallD_i) begin
            if (load) begin
                instr_d  = load_instr;
                pcd_d    = pcf_q;
                pcp4_d   = pc_plus4;
                validd_d = 1'b1;
            end else begin
                instr_d  = NOP;
                validd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pcf_q    <= RESET_PC;
            buf_q    <= '0;
            instr_q  <= NOP;
            pcd_q    <= '0;
            pcp4_q   <= XLEN'(4);
            validd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            buf_q    <= buf_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            pcp4_q   <= pcp4_d;
            validd_q <= validd_d;
        end
    end

    assign InstrD_o   = instr_q;
    assign PCD_o      = pcd_q;
    assign PCPlus4D_o = pcp4_q;
    assign ValidD_o   = validd_q;

endmodule
